// File: rtl/nios_system_ram_tester_pkg.sv
// Shared types and constants for the RAM tester: FSM state encoding,
// LFSR feedback polynomial and the maximum run length.
package nios_system_ram_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Galois feedback taps for the 32-bit pattern LFSR (right-shifting form).
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int unsigned DEF_ADDR_W = 10;

    // Words addressable by an aw-bit word address; runs are clamped to this.
    function automatic int unsigned max_len(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned MAX_LEN = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/nios_system_ram_tester_if.sv
// Avalon-MM bus between the RAM tester (master) and the target RAM (slave).
interface nios_system_ram_tester_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;

    modport master (
        output avm_address, avm_byteenable, avm_chipselect, avm_write,
               avm_clken, avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_chipselect, avm_write,
               avm_clken, avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/nios_system_ram_tester_pattern.sv
// Test-pattern generator shared by the write and read phases.
// Default: incrementing pattern seed + i.
// With NIOS_SYSTEM_RAM_TESTER_LFSR_EN defined: Galois LFSR loaded with seed
// (a zero seed is replaced by 1 so the LFSR never locks up).
module nios_system_ram_tester_pattern
    import nios_system_ram_tester_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] value
);

`ifdef NIOS_SYSTEM_RAM_TESTER_LFSR_EN
    localparam logic [DATA_W-1:0] POLY = DATA_W'(LFSR_POLY);

    // Load takes priority over advance; shift right, fold taps on a set LSB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= (seed == '0) ? DATA_W'(1) : seed;
        end else if (advance) begin
            value <= {1'b0, value[DATA_W-1:1]} ^ (value[0] ? POLY : '0);
        end
    end
`else
    // Load takes priority over advance; one increment per word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= value + DATA_W'(1);
        end
    end
`endif

endmodule

// File: rtl/nios_system_ram_tester.sv
// Built-in RAM tester: writes a pattern over a word range, reads it back and
// compares each word READ_LATENCY cycles after the read was issued.
// Optional macro NIOS_SYSTEM_RAM_TESTER_LFSR_EN selects an LFSR pattern.
module nios_system_ram_tester
    import nios_system_ram_tester_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W:0]         length,
    input  logic [DATA_W-1:0]       seed,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ADDR_W:0]         error_count,
    output logic [ADDR_W-1:0]       first_err_addr,
    nios_system_ram_tester_if.master avm
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(max_len(ADDR_W));
    localparam int unsigned     DRAIN_W = $clog2(READ_LATENCY + 1);

    state_t               state, state_next;
    logic [ADDR_W-1:0]    addr_r, base_r;
    logic [ADDR_W:0]      cnt, len_r, len_clamped;
    logic [DATA_W-1:0]    seed_r, pat_value, pat_seed;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 pass_r;
    logic                 last_word, pat_load, pat_advance, mismatch;

    logic [DATA_W-1:0]    dl_data [READ_LATENCY];
    logic [ADDR_W-1:0]    dl_addr [READ_LATENCY];
    logic [READ_LATENCY-1:0] dl_vld;

    assign len_clamped = (length > LEN_MAX) ? LEN_MAX : length;
    assign last_word   = (cnt == (ADDR_W + 1)'(1));
    assign pat_load    = ((state == ST_IDLE) && start) || ((state == ST_WRITE) && last_word);
    assign pat_advance = (state == ST_WRITE) || (state == ST_READ);
    assign pat_seed    = (state == ST_IDLE) ? seed : seed_r;
    assign mismatch    = dl_vld[READ_LATENCY-1] &&
                         (avm.avm_readdata != dl_data[READ_LATENCY-1]);

    nios_system_ram_tester_pattern #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (pat_load),
        .advance (pat_advance),
        .seed    (pat_seed),
        .value   (pat_value)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state decode and bus/status outputs.
    always_comb begin
        state_next          = state;
        busy                = 1'b1;
        done                = 1'b0;
        avm.avm_chipselect  = 1'b0;
        avm.avm_write       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = (len_clamped == '0) ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write      = 1'b1;
                if (last_word) state_next = ST_READ;
            end
            ST_READ: begin
                avm.avm_chipselect = 1'b1;
                if (last_word) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_W'(1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        avm.avm_clken      = busy;
        avm.avm_address    = addr_r;
        avm.avm_byteenable = '1;
        avm.avm_writedata  = pat_value;
        // The last compare lands on the edge entering DONE, so pass is
        // derived live during DONE and held in pass_r afterwards.
        pass = done ? (error_count == '0) : pass_r;
    end

    // Run bookkeeping: address walk, word count, drain timer, results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r         <= '0;
            base_r         <= '0;
            cnt            <= '0;
            len_r          <= '0;
            seed_r         <= '0;
            drain_cnt      <= '0;
            pass_r         <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_r         <= base_addr;
                        base_r         <= base_addr;
                        cnt            <= len_clamped;
                        len_r          <= len_clamped;
                        seed_r         <= seed;
                        pass_r         <= 1'b0;
                        error_count    <= '0;
                        first_err_addr <= '0;
                    end
                end
                ST_WRITE: begin
                    if (last_word) begin
                        addr_r <= base_r;
                        cnt    <= len_r;
                    end else begin
                        addr_r <= addr_r + ADDR_W'(1);
                        cnt    <= cnt - (ADDR_W + 1)'(1);
                    end
                end
                ST_READ: begin
                    addr_r <= addr_r + ADDR_W'(1);
                    cnt    <= cnt - (ADDR_W + 1)'(1);
                    if (last_word) drain_cnt <= DRAIN_W'(READ_LATENCY);
                end
                ST_DRAIN: drain_cnt <= drain_cnt - DRAIN_W'(1);
                ST_DONE:  pass_r    <= (error_count == '0);
                default: ;
            endcase
            if (mismatch) begin
                error_count <= error_count + (ADDR_W + 1)'(1);
                if (error_count == '0) first_err_addr <= dl_addr[READ_LATENCY-1];
            end
        end
    end

    // Expected-data delay line aligned with the RAM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_vld <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                dl_data[i] <= '0;
                dl_addr[i] <= '0;
            end
        end else begin
            dl_vld[0]  <= (state == ST_READ);
            dl_data[0] <= pat_value;
            dl_addr[0] <= addr_r;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_data[i] <= dl_data[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_nios_system_ram_tester.sv
// Directed testbench for nios_system_ram_tester with a 1-cycle-latency RAM
// model that can corrupt bit 0 of one address on readback.
module tb_nios_system_ram_tester;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] seed;
    logic          busy, done, pass;
    logic [AW:0]   error_count;
    logic [AW-1:0] first_err_addr;

    int n_vec = 0;
    int n_err = 0;

    nios_system_ram_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    nios_system_ram_tester #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .first_err_addr (first_err_addr),
        .avm            (bus)
    );

    always #5 clk = ~clk;

    // RAM model
    logic [DW-1:0] mem [1024];
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (bus.avm_chipselect && bus.avm_write)
            mem[bus.avm_address] <= bus.avm_writedata;
        if (bus.avm_chipselect && !bus.avm_write)
            bus.avm_readdata <= mem[bus.avm_address] ^
                ((corrupt_en && bus.avm_address == corrupt_addr) ? 32'd1 : 32'd0);
    end

    // Bus monitor
    logic [AW-1:0] wr_addr [1100];
    logic [DW-1:0] wr_data [1100];
    logic [AW-1:0] rd_addr [1100];
    int wn = 0, rn = 0, be_bad = 0, cs_idle = 0;

    always @(negedge clk) begin
        if (bus.avm_chipselect && (!busy || done)) cs_idle++;
        if (bus.avm_chipselect && bus.avm_write) begin
            if (bus.avm_byteenable !== 4'hF) be_bad++;
            if (wn < 1100) begin wr_addr[wn] = bus.avm_address; wr_data[wn] = bus.avm_writedata; end
            wn++;
        end else if (bus.avm_chipselect) begin
            if (rn < 1100) rd_addr[rn] = bus.avm_address;
            rn++;
        end
    end

    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] s, input int unsigned i);
`ifdef NIOS_SYSTEM_RAM_TESTER_LFSR_EN
        logic [DW-1:0] v;
        v = (s == '0) ? 32'd1 : s;
        for (int unsigned k = 0; k < i; k++)
            v = {1'b0, v[DW-1:1]} ^ (v[0] ? 32'h8020_0003 : 32'd0);
        return v;
`else
        return s + DW'(i);
`endif
    endfunction

    task automatic run(input logic [AW-1:0] b, input logic [AW:0] n, input logic [DW-1:0] s,
                       output int cyc);
        wn = 0; rn = 0; be_bad = 0; cs_idle = 0;
        @(negedge clk);
        base_addr = b; length = n; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 4000) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; seed = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got %b exp 0", pass); end
        n_vec++; if (error_count !== 11'd0) begin n_err++; $display("FAIL reset_errcnt got %0d exp 0", error_count); end
        n_vec++; if (first_err_addr !== 10'd0) begin n_err++; $display("FAIL reset_firsterr got %0h exp 0", first_err_addr); end
        n_vec++; if (bus.avm_chipselect !== 1'b0 || bus.avm_write !== 1'b0 || bus.avm_clken !== 1'b0)
            begin n_err++; $display("FAIL reset_bus got cs=%b wr=%b ck=%b exp 000", bus.avm_chipselect, bus.avm_write, bus.avm_clken); end
        n_vec++; if (bus.avm_address !== 10'd0) begin n_err++; $display("FAIL reset_addr got %0h exp 0", bus.avm_address); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        run(10'h000, 11'd4, 32'h100, cyc);
        n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL basic_cycles got %0d exp 10", cyc); end
        n_vec++; if (bus.avm_clken !== 1'b1) begin n_err++; $display("FAIL basic_clken_done got %b exp 1", bus.avm_clken); end
        n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL basic_pass got %b exp 1", pass); end
        n_vec++; if (error_count !== 11'd0) begin n_err++; $display("FAIL basic_errcnt got %0d exp 0", error_count); end
        n_vec++; if (wn !== 4 || rn !== 4) begin n_err++; $display("FAIL basic_counts got w=%0d r=%0d exp 4/4", wn, rn); end
        n_vec++; if (be_bad !== 0) begin n_err++; $display("FAIL basic_byteenable got %0d bad exp 0", be_bad); end
        for (int unsigned i = 0; i < 4; i++) begin
            n_vec++; if (wr_addr[i] !== AW'(i) || rd_addr[i] !== AW'(i))
                begin n_err++; $display("FAIL basic_addr[%0d] got w=%0h r=%0h exp %0h", i, wr_addr[i], rd_addr[i], i); end
            n_vec++; if (wr_data[i] !== exp_word(32'h100, i))
                begin n_err++; $display("FAIL basic_wdata[%0d] got %0h exp %0h", i, wr_data[i], exp_word(32'h100, i)); end
        end
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_after got done=%b busy=%b exp 0 0", done, busy); end
        n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL basic_pass_hold got %b exp 1", pass); end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [AW-1:0] ea [4];
        ea[0] = 10'h3FE; ea[1] = 10'h3FF; ea[2] = 10'h000; ea[3] = 10'h001;
        run(10'h3FE, 11'd4, 32'hABCD_0000, cyc);
        n_vec++; if (wn !== 4 || rn !== 4) begin n_err++; $display("FAIL wrap_counts got w=%0d r=%0d exp 4/4", wn, rn); end
        for (int unsigned i = 0; i < 4; i++) begin
            n_vec++; if (wr_addr[i] !== ea[i] || rd_addr[i] !== ea[i])
                begin n_err++; $display("FAIL wrap_addr[%0d] got w=%0h r=%0h exp %0h", i, wr_addr[i], rd_addr[i], ea[i]); end
        end
        n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL wrap_pass got %b exp 1", pass); end
    endtask

    task automatic test_corrupt();
        int cyc;
        corrupt_en = 1'b1; corrupt_addr = 10'd5;
        run(10'h000, 11'd16, 32'h1234_5678, cyc);
        n_vec++; if (cyc !== 34) begin n_err++; $display("FAIL corrupt_cycles got %0d exp 34", cyc); end
        n_vec++; if (error_count !== 11'd1) begin n_err++; $display("FAIL corrupt_errcnt got %0d exp 1", error_count); end
        n_vec++; if (first_err_addr !== 10'd5) begin n_err++; $display("FAIL corrupt_firsterr got %0h exp 5", first_err_addr); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL corrupt_pass got %b exp 0", pass); end
        @(negedge clk);
        n_vec++; if (error_count !== 11'd1 || first_err_addr !== 10'd5 || pass !== 1'b0)
            begin n_err++; $display("FAIL corrupt_hold got cnt=%0d fa=%0h pass=%b exp 1 5 0", error_count, first_err_addr, pass); end
        corrupt_en = 1'b0;
    endtask

    task automatic test_len_zero();
        int cyc;
        run(10'h000, 11'd0, 32'h55, cyc);
        n_vec++; if (cyc !== 1) begin n_err++; $display("FAIL len0_cycles got %0d exp 1", cyc); end
        n_vec++; if (wn !== 0 || rn !== 0 || cs_idle !== 0) begin n_err++; $display("FAIL len0_bus got w=%0d r=%0d exp 0/0", wn, rn); end
        n_vec++; if (pass !== 1'b1 || error_count !== 11'd0) begin n_err++; $display("FAIL len0_result got pass=%b cnt=%0d exp 1 0", pass, error_count); end
    endtask

    task automatic test_clamp();
        int cyc;
        run(10'h010, 11'd2000, 32'hDEAD_0000, cyc);
        n_vec++; if (cyc !== 2050) begin n_err++; $display("FAIL clamp_cycles got %0d exp 2050", cyc); end
        n_vec++; if (wn !== 1024 || rn !== 1024) begin n_err++; $display("FAIL clamp_counts got w=%0d r=%0d exp 1024/1024", wn, rn); end
        n_vec++; if (wr_addr[0] !== 10'h010 || wr_addr[1023] !== 10'h00F || rd_addr[1023] !== 10'h00F)
            begin n_err++; $display("FAIL clamp_addr got %0h %0h %0h exp 10 f f", wr_addr[0], wr_addr[1023], rd_addr[1023]); end
        n_vec++; if (wr_data[1023] !== exp_word(32'hDEAD_0000, 1023))
            begin n_err++; $display("FAIL clamp_wdata got %0h exp %0h", wr_data[1023], exp_word(32'hDEAD_0000, 1023)); end
        n_vec++; if (pass !== 1'b1 || error_count !== 11'd0) begin n_err++; $display("FAIL clamp_result got pass=%b cnt=%0d exp 1 0", pass, error_count); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        corrupt_en = 1'b1; corrupt_addr = 10'd2;
        wn = 0; rn = 0;
        @(negedge clk);
        base_addr = 10'h000; length = 11'd16; seed = 32'h5000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rn < 6 && cyc < 100) begin @(negedge clk); cyc++; end
        n_vec++; if (bus.avm_chipselect !== 1'b1 || bus.avm_write !== 1'b0)
            begin n_err++; $display("FAIL midrst_in_read got cs=%b wr=%b exp 1 0", bus.avm_chipselect, bus.avm_write); end
        n_vec++; if (error_count !== 11'd1 || first_err_addr !== 10'd2)
            begin n_err++; $display("FAIL midrst_pre got cnt=%0d fa=%0h exp 1 2", error_count, first_err_addr); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
            begin n_err++; $display("FAIL midrst_status got busy=%b done=%b pass=%b exp 000", busy, done, pass); end
        n_vec++; if (error_count !== 11'd0 || first_err_addr !== 10'd0)
            begin n_err++; $display("FAIL midrst_results got cnt=%0d fa=%0h exp 0 0", error_count, first_err_addr); end
        n_vec++; if (bus.avm_chipselect !== 1'b0 || bus.avm_write !== 1'b0 || bus.avm_clken !== 1'b0 || bus.avm_address !== 10'd0)
            begin n_err++; $display("FAIL midrst_bus got cs=%b wr=%b ck=%b a=%0h exp 0 0 0 0", bus.avm_chipselect, bus.avm_write, bus.avm_clken, bus.avm_address); end
        @(negedge clk);
        reset_n = 1'b1;
        corrupt_en = 1'b0;
        run(10'h040, 11'd8, 32'h9000, cyc);
        n_vec++; if (cyc !== 18 || wn !== 8 || rn !== 8) begin n_err++; $display("FAIL midrst_rerun got cyc=%0d w=%0d r=%0d exp 18 8 8", cyc, wn, rn); end
        n_vec++; if (pass !== 1'b1 || error_count !== 11'd0) begin n_err++; $display("FAIL midrst_rerun_result got pass=%b cnt=%0d exp 1 0", pass, error_count); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        wn = 0; rn = 0;
        @(negedge clk);
        base_addr = 10'h020; length = 11'd8; seed = 32'h7000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        base_addr = 10'h300; length = 11'd3; seed = 32'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (done !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
        n_vec++; if (cyc !== 18) begin n_err++; $display("FAIL busy_cycles got %0d exp 18", cyc); end
        n_vec++; if (wn !== 8 || wr_addr[0] !== 10'h020 || wr_addr[7] !== 10'h027 || rd_addr[7] !== 10'h027)
            begin n_err++; $display("FAIL busy_addr got w=%0d %0h %0h %0h exp 8 20 27 27", wn, wr_addr[0], wr_addr[7], rd_addr[7]); end
        n_vec++; if (wr_data[7] !== exp_word(32'h7000, 7)) begin n_err++; $display("FAIL busy_wdata got %0h exp %0h", wr_data[7], exp_word(32'h7000, 7)); end
        // start presented during DONE must also be dropped
        base_addr = 10'h000; length = 11'd4; seed = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL done_start_ignored got busy=%b exp 0", busy); end
        @(negedge clk);
    endtask

`ifdef NIOS_SYSTEM_RAM_TESTER_LFSR_EN
    task automatic test_lfsr();
        int cyc;
        run(10'h000, 11'd4, 32'h0, cyc);
        n_vec++; if (wr_data[0] !== 32'h0000_0001) begin n_err++; $display("FAIL lfsr_first got %0h exp 1", wr_data[0]); end
        n_vec++; if (wr_data[1] !== 32'h8020_0003) begin n_err++; $display("FAIL lfsr_second got %0h exp 80200003", wr_data[1]); end
        n_vec++; if (pass !== 1'b1 || error_count !== 11'd0) begin n_err++; $display("FAIL lfsr_pass got pass=%b cnt=%0d exp 1 0", pass, error_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_corrupt();
        test_len_zero();
        test_clamp();
        test_reset_mid();
        test_start_while_busy();
`ifdef NIOS_SYSTEM_RAM_TESTER_LFSR_EN
        test_lfsr();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nios_system_ram_tester.md
NIOS_SYSTEM_RAM_TESTER -- requirements
Module: nios_system_ram_tester

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, word-address width of the target RAM.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width of the target RAM.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, fixed cycles from read-address issue to valid avm_readdata.
REQ-004 The block SHALL have port clk  input  1  the single clock, all logic rising-edge.
REQ-005 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port start  input  1  one-cycle request to run a test.
REQ-007 The block SHALL have port base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-008 The block SHALL have port length  input  ADDR_W+1  word count, sampled on accepted start.
REQ-009 The block SHALL have port seed  input  DATA_W  pattern seed, sampled on accepted start.
REQ-010 The block SHALL have ports busy, done, pass  output  1 each  run active, one-cycle completion pulse, last-run result.
REQ-011 The block SHALL have ports error_count  output  ADDR_W+1 and first_err_addr  output  ADDR_W  with last-run results.
REQ-012 The block SHALL have Avalon-MM master ports avm_address  output  ADDR_W, avm_byteenable  output  DATA_W/8, avm_chipselect, avm_write, avm_clken  output  1 each.
REQ-013 The block SHALL have Avalon-MM master ports avm_writedata  output  DATA_W and avm_readdata  input  DATA_W.

Function
REQ-014 States SHALL be IDLE, WRITE, READ, DRAIN, DONE.
REQ-015 Start SHALL be accepted only in IDLE; start in any other state SHALL be ignored.
REQ-016 Length greater than 2^ADDR_W SHALL be clamped to 2^ADDR_W; length 0 SHALL go IDLE->DONE with no bus cycles, pass=1, error_count=0.
REQ-017 WRITE SHALL issue one write per cycle: chipselect=1, write=1, byteenable all ones, address = (base_addr+i) mod 2^ADDR_W, i = 0..length-1.
REQ-018 After the last write, READ SHALL issue one read per cycle (chipselect=1, write=0) over the same address sequence, starting from the same pattern seed.
REQ-019 Expected data and address SHALL travel in a READ_LATENCY-deep delay line; avm_readdata SHALL be compared exactly READ_LATENCY cycles after issue.
REQ-020 DRAIN SHALL last READ_LATENCY cycles with chipselect=0, completing outstanding compares, then enter DONE.
REQ-021 Each mismatch SHALL increment error_count; the first mismatch of a run SHALL latch first_err_addr.
REQ-022 DONE SHALL last one cycle with done=1, pass=(error_count==0), then return to IDLE.
REQ-023 busy SHALL be 1 in WRITE, READ, DRAIN, DONE; avm_clken SHALL be 1 whenever busy.
REQ-024 chipselect SHALL be 0 in IDLE and DONE; avm_writedata SHALL be don't-care when write=0.
REQ-025 Default pattern SHALL be data_i = seed + i, modulo 2^DATA_W.
REQ-026 error_count and first_err_addr SHALL clear on accepted start and hold after DONE until next start.

Reset
REQ-027 Assertion of reset_n=0 SHALL immediately force IDLE, busy=0, done=0, pass=0, error_count=0, first_err_addr=0, chipselect=0, write=0, address=0, clken=0, abandoning any run.
REQ-028 The delay line and pattern generator SHALL be cleared by reset.

Configuration
REQ-029 With macro NIOS_SYSTEM_RAM_TESTER_LFSR_EN defined, pattern SHALL be a DATA_W Galois LFSR (polynomial 0x80200003 for 32 bits) loaded with seed (0 replaced by 1), advanced once per word, reloaded for READ.
REQ-030 Without NIOS_SYSTEM_RAM_TESTER_LFSR_EN, the pattern SHALL be the incrementing pattern of REQ-025 and no LFSR logic SHALL be present.

Structure
REQ-031 Package nios_system_ram_tester_pkg SHALL hold the state enum, LFSR polynomial constant and MAX_LEN = 2^ADDR_W.
REQ-032 One sub-module, nios_system_ram_tester_pattern (load, advance, value), SHALL generate the pattern for both phases.

Verification
REQ-033 base_addr=0, length=4, seed=0x100, healthy RAM -> writes 0x100..0x103 to addresses 0..3, reads 0..3, done pulse, pass=1, error_count=0.
REQ-034 base_addr=0x3FE, length=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001 in both phases.
REQ-035 Bench RAM corrupts bit 0 at address 5, base 0, length 16 -> error_count=1, first_err_addr=5, pass=0.
REQ-036 length=0 -> no chipselect, done one cycle after start, pass=1; length=2000 -> exactly 1024 writes and 1024 reads.
REQ-037 reset_n=0 during READ -> all outputs at reset values same cycle; subsequent start runs cleanly; start pulsed while busy is ignored.
REQ-038 NIOS_SYSTEM_RAM_TESTER_LFSR_EN defined, seed=0 -> first written word 0x00000001, read-phase compares pass on healthy RAM.
